// File: rtl/mem_arbiter_pkg.sv
// Shared configuration for the memory arbiter: widths, write-size codes,
// FSM state and owner encodings.
package mem_arbiter_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int SIGS_WIDTH = 8;
  localparam int CNT_W      = 4;

  localparam logic [SIGS_WIDTH-1:0] MEM_BYT_1_U = 8'd1;
  localparam logic [SIGS_WIDTH-1:0] MEM_BYT_2_U = 8'd2;
  localparam logic [SIGS_WIDTH-1:0] MEM_BYT_4_U = 8'd4;
  localparam logic [SIGS_WIDTH-1:0] MEM_BYT_8_U = 8'd8;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    ARB_OWN_IFU = 1'b0,
    ARB_OWN_LSU = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of IFU, LSU and memory-port signals around the arbiter; the slave
// modport is the arbiter's view, master is the core/memory side.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_WIDTH,
  parameter int BYT_W  = SIGS_WIDTH
);

  logic              pIfu_iReqValid;
  logic [DATA_W-1:0] pIfu_iAddr;
  logic              pIfu_oReqReady;
  logic              pIfu_oRspValid;
  logic [DATA_W-1:0] pIfu_oRdData;

  logic              pLsu_iReqValid;
  logic              pLsu_iWrEn;
  logic [DATA_W-1:0] pLsu_iAddr;
  logic [DATA_W-1:0] pLsu_iWrData;
  logic [BYT_W-1:0]  pLsu_iWrByt;
  logic              pLsu_oReqReady;
  logic              pLsu_oRspValid;
  logic [DATA_W-1:0] pLsu_oRdData;

  logic              pMem_oRdEn;
  logic              pMem_oWrEn;
  logic [DATA_W-1:0] pMem_oAddr;
  logic [DATA_W-1:0] pMem_oWrData;
  logic [BYT_W-1:0]  pMem_oWrByt;
  logic [DATA_W-1:0] pMem_iRdData;

  modport slave (
    input  pIfu_iReqValid, pIfu_iAddr,
    output pIfu_oReqReady, pIfu_oRspValid, pIfu_oRdData,
    input  pLsu_iReqValid, pLsu_iWrEn, pLsu_iAddr, pLsu_iWrData, pLsu_iWrByt,
    output pLsu_oReqReady, pLsu_oRspValid, pLsu_oRdData,
    output pMem_oRdEn, pMem_oWrEn, pMem_oAddr, pMem_oWrData, pMem_oWrByt,
    input  pMem_iRdData
  );

  modport master (
    output pIfu_iReqValid, pIfu_iAddr,
    input  pIfu_oReqReady, pIfu_oRspValid, pIfu_oRdData,
    output pLsu_iReqValid, pLsu_iWrEn, pLsu_iAddr, pLsu_iWrData, pLsu_iWrByt,
    input  pLsu_oReqReady, pLsu_oRspValid, pLsu_oRdData,
    input  pMem_oRdEn, pMem_oWrEn, pMem_oAddr, pMem_oWrData, pMem_oWrByt,
    output pMem_iRdData
  );

endinterface

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker: bit 0 is the IFU, bit 1 the LSU. On a tie the
// requester that was not granted last wins.
module mem_arb_rr (
  input  logic [1:0] valid,
  input  logic       last_lsu,
  output logic [1:0] grant
);

  assign grant[0] = valid[0] & (~valid[1] |  last_lsu);
  assign grant[1] = valid[1] & (~valid[0] | ~last_lsu);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter and sequencer for the shared single-port memory: grants one
// requester, holds the memory port for MEM_LAT cycles, then pulses a response.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_W  = DATA_WIDTH,
  parameter int BYT_W   = SIGS_WIDTH,
  parameter int MEM_LAT = 1
) (
  input  logic          iClock,
  input  logic          iReset,
  mem_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

  arb_state_t        state;
  arb_owner_t        owner;
  arb_owner_t        last_own;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        grant;

  logic              mem_rd_en;
  logic              mem_wr_en;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic [BYT_W-1:0]  mem_wr_byt;

  logic              ifu_rsp_valid;
  logic              lsu_rsp_valid;
  logic [DATA_W-1:0] ifu_rd_data;
  logic [DATA_W-1:0] lsu_rd_data;

  mem_arb_rr u_rr (
    .valid    ({bus.pLsu_iReqValid, bus.pIfu_iReqValid}),
    .last_lsu (last_own == ARB_OWN_LSU),
    .grant    (grant)
  );

  // Ready is only offered in IDLE and is forced low while reset is held.
  assign bus.pIfu_oReqReady = iReset & (state == ARB_IDLE) & grant[0];
  assign bus.pLsu_oReqReady = iReset & (state == ARB_IDLE) & grant[1];

  assign bus.pIfu_oRspValid = ifu_rsp_valid;
  assign bus.pIfu_oRdData   = ifu_rd_data;
  assign bus.pLsu_oRspValid = lsu_rsp_valid;
  assign bus.pLsu_oRdData   = lsu_rd_data;

  assign bus.pMem_oRdEn     = mem_rd_en;
  assign bus.pMem_oWrEn     = mem_wr_en;
  assign bus.pMem_oAddr     = mem_addr;
  assign bus.pMem_oWrData   = mem_wr_data;
  assign bus.pMem_oWrByt    = mem_wr_byt;

  // The accepted request is latched into the port registers at the grant
  // edge, so the memory sees a stable request for the whole ACCESS window.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state         <= ARB_IDLE;
      owner         <= ARB_OWN_IFU;
      last_own      <= ARB_OWN_LSU;
      cnt           <= '0;
      mem_rd_en     <= 1'b0;
      mem_wr_en     <= 1'b0;
      mem_addr      <= '0;
      mem_wr_data   <= '0;
      mem_wr_byt    <= '0;
      ifu_rsp_valid <= 1'b0;
      lsu_rsp_valid <= 1'b0;
      ifu_rd_data   <= '0;
      lsu_rd_data   <= '0;
    end else begin
      ifu_rsp_valid <= 1'b0;
      lsu_rsp_valid <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (grant[0]) begin
            mem_rd_en   <= 1'b1;
            mem_wr_en   <= 1'b0;
            mem_addr    <= bus.pIfu_iAddr;
            mem_wr_data <= '0;
            mem_wr_byt  <= '0;
            owner       <= ARB_OWN_IFU;
            last_own    <= ARB_OWN_IFU;
            cnt         <= CNT_INIT;
            state       <= ARB_ACCESS;
          end else if (grant[1]) begin
            mem_rd_en   <= ~bus.pLsu_iWrEn;
            mem_wr_en   <= bus.pLsu_iWrEn;
            mem_addr    <= bus.pLsu_iAddr;
            mem_wr_data <= bus.pLsu_iWrData;
            mem_wr_byt  <= bus.pLsu_iWrByt;
            owner       <= ARB_OWN_LSU;
            last_own    <= ARB_OWN_LSU;
            cnt         <= CNT_INIT;
            state       <= ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          if (cnt == '0) begin
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            if (owner == ARB_OWN_IFU) begin
              ifu_rd_data   <= bus.pMem_iRdData;
              ifu_rsp_valid <= 1'b1;
            end else begin
              lsu_rd_data   <= mem_wr_en ? '0 : bus.pMem_iRdData;
              lsu_rsp_valid <= 1'b1;
            end
            state <= ARB_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ARB_RESP: begin
          state <= ARB_IDLE;
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with MEM_LAT=1 for the main
// sequence and one with MEM_LAT=3 for the long-latency load.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clock;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  mem_arbiter_if #(.DATA_W(64), .BYT_W(8)) bus_a ();
  mem_arbiter_if #(.DATA_W(64), .BYT_W(8)) bus_b ();

  mem_arbiter #(.DATA_W(64), .BYT_W(8), .MEM_LAT(1)) dut_a (
    .iClock (clock),
    .iReset (reset_n),
    .bus    (bus_a.slave)
  );

  mem_arbiter #(.DATA_W(64), .BYT_W(8), .MEM_LAT(3)) dut_b (
    .iClock (clock),
    .iReset (reset_n),
    .bus    (bus_b.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ifu_v, input logic [63:0] ifu_addr,
                               input logic lsu_v, input logic lsu_we,
                               input logic [63:0] lsu_addr, input logic [63:0] lsu_wd,
                               input logic [7:0] lsu_byt, input logic [63:0] mem_rd);
    bus_a.pIfu_iReqValid = ifu_v;
    bus_a.pIfu_iAddr     = ifu_addr;
    bus_a.pLsu_iReqValid = lsu_v;
    bus_a.pLsu_iWrEn     = lsu_we;
    bus_a.pLsu_iAddr     = lsu_addr;
    bus_a.pLsu_iWrData   = lsu_wd;
    bus_a.pLsu_iWrByt    = lsu_byt;
    bus_a.pMem_iRdData   = mem_rd;
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    bus_b.pIfu_iReqValid = 1'b0;
    bus_b.pIfu_iAddr     = '0;
    bus_b.pLsu_iReqValid = 1'b0;
    bus_b.pLsu_iWrEn     = 1'b0;
    bus_b.pLsu_iAddr     = '0;
    bus_b.pLsu_iWrData   = '0;
    bus_b.pLsu_iWrByt    = '0;
    bus_b.pMem_iRdData   = '0;
    applyStimulus(1'b1, 64'h8000_0000, 1'b0, 1'b0, '0, '0, '0, 64'h13);

    // Reset state: ready held low even with a valid request pending.
    @(posedge clock);
    nextCycle();
    checkOutput("rst_ifu_ready", 64'(bus_a.pIfu_oReqReady), 64'd0);
    checkOutput("rst_rd_en", 64'(bus_a.pMem_oRdEn), 64'd0);
    checkOutput("rst_ifu_rsp", 64'(bus_a.pIfu_oRspValid), 64'd0);
    checkOutput("rst_addr", bus_a.pMem_oAddr, 64'd0);
    reset_n = 1'b1;

    // IFU fetch with MEM_LAT=1.
    sample();
    checkOutput("t1_ifu_ready", 64'(bus_a.pIfu_oReqReady), 64'd1);
    checkOutput("t1_lsu_ready", 64'(bus_a.pLsu_oReqReady), 64'd0);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 64'h13);
    sample();
    checkOutput("t1_rd_en", 64'(bus_a.pMem_oRdEn), 64'd1);
    checkOutput("t1_wr_en", 64'(bus_a.pMem_oWrEn), 64'd0);
    checkOutput("t1_addr", bus_a.pMem_oAddr, 64'h8000_0000);
    checkOutput("t1_rsp_early", 64'(bus_a.pIfu_oRspValid), 64'd0);
    nextCycle();
    sample();
    checkOutput("t1_ifu_rsp", 64'(bus_a.pIfu_oRspValid), 64'd1);
    checkOutput("t1_ifu_data", bus_a.pIfu_oRdData, 64'h13);
    checkOutput("t1_lsu_rsp", 64'(bus_a.pLsu_oRspValid), 64'd0);
    checkOutput("t1_rd_en_resp", 64'(bus_a.pMem_oRdEn), 64'd0);
    nextCycle();
    sample();
    checkOutput("t1_rsp_done", 64'(bus_a.pIfu_oRspValid), 64'd0);
    checkOutput("t1_data_hold", bus_a.pIfu_oRdData, 64'h13);

    // LSU store: write ack returns zero data.
    nextCycle();
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 64'h8000_0100, 64'hDEAD_BEEF, MEM_BYT_4_U, 64'h5555);
    sample();
    checkOutput("t2_lsu_ready", 64'(bus_a.pLsu_oReqReady), 64'd1);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 64'h5555);
    sample();
    checkOutput("t2_wr_en", 64'(bus_a.pMem_oWrEn), 64'd1);
    checkOutput("t2_rd_en", 64'(bus_a.pMem_oRdEn), 64'd0);
    checkOutput("t2_addr", bus_a.pMem_oAddr, 64'h8000_0100);
    checkOutput("t2_wdata", bus_a.pMem_oWrData, 64'hDEAD_BEEF);
    checkOutput("t2_wbyt", 64'(bus_a.pMem_oWrByt), 64'(MEM_BYT_4_U));
    nextCycle();
    sample();
    checkOutput("t2_lsu_rsp", 64'(bus_a.pLsu_oRspValid), 64'd1);
    checkOutput("t2_lsu_data", bus_a.pLsu_oRdData, 64'd0);
    checkOutput("t2_wr_en_resp", 64'(bus_a.pMem_oWrEn), 64'd0);
    checkOutput("t2_ifu_rsp", 64'(bus_a.pIfu_oRspValid), 64'd0);

    // Both requesters valid for four transactions: grants alternate from IFU.
    for (int t = 0; t < 4; t++) begin
      nextCycle();
      applyStimulus(1'b1, 64'h1000, 1'b1, 1'b0, 64'h2000, '0, '0, 64'hA0 + 64'(t));
      sample();
      checkOutput($sformatf("t3_ifu_ready_%0d", t), 64'(bus_a.pIfu_oReqReady), (t % 2 == 0) ? 64'd1 : 64'd0);
      checkOutput($sformatf("t3_lsu_ready_%0d", t), 64'(bus_a.pLsu_oReqReady), (t % 2 == 1) ? 64'd1 : 64'd0);
      nextCycle();
      sample();
      checkOutput($sformatf("t3_addr_%0d", t), bus_a.pMem_oAddr, (t % 2 == 0) ? 64'h1000 : 64'h2000);
      checkOutput($sformatf("t3_busy_ready_%0d", t), 64'({bus_a.pIfu_oReqReady, bus_a.pLsu_oReqReady}), 64'd0);
      nextCycle();
      sample();
      checkOutput($sformatf("t3_ifu_rsp_%0d", t), 64'(bus_a.pIfu_oRspValid), (t % 2 == 0) ? 64'd1 : 64'd0);
      checkOutput($sformatf("t3_lsu_rsp_%0d", t), 64'(bus_a.pLsu_oRspValid), (t % 2 == 1) ? 64'd1 : 64'd0);
      checkOutput($sformatf("t3_data_%0d", t),
                  (t % 2 == 0) ? bus_a.pIfu_oRdData : bus_a.pLsu_oRdData, 64'hA0 + 64'(t));
      checkOutput($sformatf("t3_resp_ready_%0d", t), 64'({bus_a.pIfu_oReqReady, bus_a.pLsu_oReqReady}), 64'd0);
    end

    // LSU becomes valid while IFU owns the port; it waits for IDLE.
    nextCycle();
    applyStimulus(1'b1, 64'h3000, 1'b0, 1'b0, '0, '0, '0, 64'h42);
    sample();
    checkOutput("t6_ifu_ready", 64'(bus_a.pIfu_oReqReady), 64'd1);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 64'h4000, 64'h1234_5678_9ABC_DEF0, MEM_BYT_8_U, 64'h42);
    sample();
    checkOutput("t6_lsu_wait_acc", 64'(bus_a.pLsu_oReqReady), 64'd0);
    nextCycle();
    sample();
    checkOutput("t6_lsu_wait_resp", 64'(bus_a.pLsu_oReqReady), 64'd0);
    checkOutput("t6_ifu_rsp", 64'(bus_a.pIfu_oRspValid), 64'd1);
    nextCycle();
    sample();
    checkOutput("t6_lsu_ready", 64'(bus_a.pLsu_oReqReady), 64'd1);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 64'h42);
    sample();
    checkOutput("t6_addr", bus_a.pMem_oAddr, 64'h4000);
    checkOutput("t6_wdata", bus_a.pMem_oWrData, 64'h1234_5678_9ABC_DEF0);
    checkOutput("t6_wbyt", 64'(bus_a.pMem_oWrByt), 64'(MEM_BYT_8_U));
    checkOutput("t6_wr_en", 64'(bus_a.pMem_oWrEn), 64'd1);
    nextCycle();
    sample();
    checkOutput("t6_lsu_rsp", 64'(bus_a.pLsu_oRspValid), 64'd1);

    // Reset during ACCESS of an IFU read drops the transaction.
    nextCycle();
    applyStimulus(1'b1, 64'h5000, 1'b0, 1'b0, '0, '0, '0, 64'h99);
    sample();
    checkOutput("t5_ifu_ready", 64'(bus_a.pIfu_oReqReady), 64'd1);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 64'h99);
    #1;
    checkOutput("t5_rd_en_acc", 64'(bus_a.pMem_oRdEn), 64'd1);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("t5_rd_en_rst", 64'(bus_a.pMem_oRdEn), 64'd0);
    checkOutput("t5_addr_rst", bus_a.pMem_oAddr, 64'd0);
    checkOutput("t5_data_rst", bus_a.pIfu_oRdData, 64'd0);
    nextCycle();
    reset_n = 1'b1;
    sample();
    checkOutput("t5_no_rsp_a", 64'(bus_a.pIfu_oRspValid), 64'd0);
    nextCycle();
    sample();
    checkOutput("t5_no_rsp_b", 64'({bus_a.pIfu_oRspValid, bus_a.pLsu_oRspValid}), 64'd0);
    applyStimulus(1'b1, 64'h6000, 1'b0, 1'b0, '0, '0, '0, 64'h77);
    #1;
    checkOutput("t5_ifu_ready2", 64'(bus_a.pIfu_oReqReady), 64'd1);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 64'h77);
    sample();
    checkOutput("t5_addr2", bus_a.pMem_oAddr, 64'h6000);
    nextCycle();
    sample();
    checkOutput("t5_ifu_rsp2", 64'(bus_a.pIfu_oRspValid), 64'd1);
    checkOutput("t5_ifu_data2", bus_a.pIfu_oRdData, 64'h77);

    // MEM_LAT=3 load: port held three cycles, data taken in the last one.
    nextCycle();
    bus_b.pLsu_iReqValid = 1'b1;
    bus_b.pLsu_iAddr     = 64'h8000_0200;
    sample();
    checkOutput("t4_lsu_ready", 64'(bus_b.pLsu_oReqReady), 64'd1);
    for (int c = 0; c < 3; c++) begin
      nextCycle();
      bus_b.pLsu_iReqValid = 1'b0;
      bus_b.pMem_iRdData   = 64'h111 * 64'(c + 1);
      sample();
      checkOutput($sformatf("t4_rd_en_%0d", c), 64'(bus_b.pMem_oRdEn), 64'd1);
      checkOutput($sformatf("t4_addr_%0d", c), bus_b.pMem_oAddr, 64'h8000_0200);
      checkOutput($sformatf("t4_no_rsp_%0d", c), 64'(bus_b.pLsu_oRspValid), 64'd0);
    end
    nextCycle();
    bus_b.pMem_iRdData = 64'hFFF;
    sample();
    checkOutput("t4_lsu_rsp", 64'(bus_b.pLsu_oRspValid), 64'd1);
    checkOutput("t4_lsu_data", bus_b.pLsu_oRdData, 64'h333);
    checkOutput("t4_rd_en_resp", 64'(bus_b.pMem_oRdEn), 64'd0);
    nextCycle();
    sample();
    checkOutput("t4_rsp_done", 64'(bus_b.pLsu_oRspValid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-requester arbiter and sequencer for the shared single-port embedded data/instruction memory.
- Accepts fetch requests from the IFU and load/store requests from the LSU over valid/ready handshakes.
- Grants one request at a time to the memory port and holds it for a fixed memory latency.
- Returns a one-cycle response pulse carrying read data (or a write acknowledge) to the winning requester.
- Sits between the core front/back end and the memory block; it is the only driver of the memory port.

Parameters:
DATA_W, 64, address/data width (matches `DATA_WIDTH).
BYT_W, 8, write-size code width (matches `SIGS_WIDTH; codes `MEM_BYT_*_U).
MEM_LAT, 1, cycles the memory port is held before read data is sampled (1..15).

Ports:
iClock  in  1  system clock, rising edge.
iReset  in  1  asynchronous active-low reset.
pIfu_iReqValid  in  1  IFU fetch request valid.
pIfu_iAddr  in  DATA_W  IFU fetch address.
pIfu_oReqReady  out  1  IFU request accepted this cycle.
pIfu_oRspValid  out  1  IFU read data valid, one-cycle pulse.
pIfu_oRdData  out  DATA_W  IFU read data.
pLsu_iReqValid  in  1  LSU request valid.
pLsu_iWrEn  in  1  1 = store, 0 = load.
pLsu_iAddr  in  DATA_W  LSU address.
pLsu_iWrData  in  DATA_W  store data.
pLsu_iWrByt  in  BYT_W  store size code.
pLsu_oReqReady  out  1  LSU request accepted this cycle.
pLsu_oRspValid  out  1  LSU load data / store ack, one-cycle pulse.
pLsu_oRdData  out  DATA_W  LSU load data (0 for stores).
pMem_oRdEn  out  1  memory read enable.
pMem_oWrEn  out  1  memory write enable.
pMem_oAddr  out  DATA_W  memory address.
pMem_oWrData  out  DATA_W  memory write data.
pMem_oWrByt  out  BYT_W  memory write size code.
pMem_iRdData  in  DATA_W  memory read data.

Behaviour:
- Reset (iReset=0, asynchronous): all outputs 0, FSM=IDLE, latency counter=0, last-grant flag=LSU (so IFU wins the first tie).
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any request is valid, assert oReqReady combinationally to exactly one winner, register its request into the memory-port registers, record the owner, and go to ACCESS.
  - A request is accepted only in the cycle where valid & ready.
- Arbitration when both requests are valid: round-robin; the winner is the requester not granted last. With a single valid requester, that requester always wins.
- ACCESS:
  - Memory port outputs are registered and held stable for MEM_LAT cycles; oRdEn = ~wr and oWrEn = wr for the whole window.
  - Counter runs from MEM_LAT-1 down to 0.
  - At 0, sample pMem_iRdData into the owner's oRdData register and go to RESP.
- RESP:
  - Owner's oRspValid = 1 for exactly one cycle; memory enables = 0.
  - Next state is IDLE; no new grant is made in RESP.
  - Minimum request-to-response time is MEM_LAT+2 cycles (accept edge → ACCESS → RESP).
- Stores: the response is an ack with oRdData = 0; oWrByt/oWrData are passed through unchanged.
- Response has no backpressure: requesters must be ready to take the pulse. oRdData holds its value until the next response to the same requester.
- oReqReady is never asserted outside IDLE. A requester must hold valid and payload stable until ready.
- The non-owner's oRspValid is never asserted; the two oRspValid outputs are never high together.
- Reset mid-access: the in-flight transaction is dropped, no response is issued, and enables drop immediately.
- Address and data are passed without translation; physical mapping belongs to the memory block.

Decomposition:
- Shared config include: `DATA_WIDTH, `SIGS_WIDTH, `MEM_BYT_*_U codes, plus new FSM state constants ARB_IDLE/ARB_ACCESS/ARB_RESP and owner codes ARB_OWN_IFU/ARB_OWN_LSU.
- One natural sub-module: mem_arb_rr, a 2-way round-robin picker (valid pair + last-grant in, one-hot grant out).

Test Plan:
1. Reset released, IFU req addr 0x80000000, memory returns 0x00000013 → IFU ready in cycle 0, oRdEn=1 with oAddr=0x80000000 for 1 cycle, IFU oRspValid pulse in cycle 2 with data 0x13.
2. LSU store addr 0x80000100, data 0xDEADBEEF, size `MEM_BYT_4_U → oWrEn=1 with matching addr/data/size for MEM_LAT cycles, then LSU oRspValid pulse with oRdData=0, oRdEn=0 throughout.
3. Both valid continuously for 4 transactions from reset → grants alternate IFU, LSU, IFU, LSU; each transaction spans 3 cycles; never two rspValid in one cycle.
4. MEM_LAT=3, LSU load → memory port held stable for 3 cycles, rspValid on the 5th cycle after accept, data sampled at the last ACCESS cycle.
5. iReset asserted in the ACCESS cycle of an IFU read → all outputs 0 asynchronously, no rspValid after release, next IFU request served normally.
6. LSU valid asserted during IFU ACCESS → LSU ready stays 0 until IDLE, then is granted; payload captured equals the values held by the LSU.
